keypad_emulator: RTL

//  Responder end of the 4x4 keypad scan interface. Sits where the physical

---
 rtl/keypad_emulator.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/keypad_emulator.sv
// keypad_emulator: emulates a 4x4 keypad behind a row-scanning keypad controller.
// Scripted key presses arrive on a valid/ready command port. Each press is held
// for a number of scan frames and is followed by a forced all-released gap.
module keypad_emulator #(
    parameter int unsigned HOLD_W      = 8,
    parameter int unsigned GAP_FRAMES  = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        kp_row,
    output logic [3:0]        kp_col,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [15:0]       cmd_keys,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              abort,
    output logic              busy,
    output logic              done
);

    localparam int unsigned GAP_W = (GAP_FRAMES < 1) ? 1 : $clog2(GAP_FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    logic [SYNC_STAGES-1:0][3:0]     sync_q, sync_d;
    logic [3:0]                      row_prev_q, row_prev_d;
    logic [15:0]                     keys_q, keys_d;
    logic [HOLD_W-1:0]               hold_q, hold_d;
    logic [GAP_W-1:0]                gap_q, gap_d;
    logic [3:0]                      kp_col_q, kp_col_d;
    logic                            cmd_ready_q, cmd_ready_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic [3:0]                      row_s;
    logic                            frame_tick_c;

    assign row_s        = sync_q[SYNC_STAGES-1];
    assign frame_tick_c = (row_s == 4'b1110) && (row_prev_q != 4'b1110);

    assign kp_col    = kp_col_q;
    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Row synchronizer shift chain and previous-row capture for frame detection.
    always_comb begin
        sync_d     = sync_q;
        sync_d[0]  = kp_row;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
        row_prev_d = row_s;
    end

    // Column return: a column is pulled low by any pressed key on a low row.
    always_comb begin
        kp_col_d = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_s[r] && keys_q[r*4 + c]) begin
                    kp_col_d[c] = 1'b0;
                end
            end
        end
    end

    // Press sequencer: next state, key register, frame counters and status outputs.
    always_comb begin
        state_d = state_q;
        keys_d  = keys_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                keys_d = '0;
                if (cmd_valid && cmd_ready_q) begin
                    keys_d  = cmd_keys;
                    hold_d  = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
                    state_d = S_PRESS;
                end
            end
            S_PRESS: begin
                if (abort || (frame_tick_c && (hold_q <= HOLD_W'(1)))) begin
                    keys_d = '0;
                    hold_d = '0;
                    if (GAP_FRAMES == 0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        gap_d   = GAP_W'(GAP_FRAMES);
                        state_d = S_GAP;
                    end
                end else if (frame_tick_c) begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            S_GAP: begin
                keys_d = '0;
                if (gap_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (frame_tick_c) begin
                    gap_d = gap_q - GAP_W'(1);
                    if (gap_q == GAP_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                keys_d  = '0;
                state_d = S_IDLE;
            end
        endcase
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync_q      <= '1;
            row_prev_q  <= 4'b1111;
            keys_q      <= '0;
            hold_q      <= '0;
            gap_q       <= '0;
            kp_col_q    <= 4'b1111;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            row_prev_q  <= row_prev_d;
            keys_q      <= keys_d;
            hold_q      <= hold_d;
            gap_q       <= gap_d;
            kp_col_q    <= kp_col_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule
